// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the pipeline: instruction codes, register IDs and status codes.
package y86_pkg;
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;
endpackage

// File: rtl/y86_regfile.sv
// Architectural register file: two combinational reads, two writes where the M port wins a collision.
module y86_regfile
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREGS  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        srcA,
    input  logic [3:0]        srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    input  logic [3:0]        dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic [3:0]        dstM,
    input  logic [DATA_W-1:0] valM
);
    logic [NREGS-1:0][DATA_W-1:0] regs;

    // RNONE never matches a real register index, so it writes nothing.
    for (genvar i = 0; i < NREGS; i++) begin : gReg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                regs[i] <= '0;
            else if (dstM == 4'(i))    regs[i] <= valM;
            else if (dstE == 4'(i))    regs[i] <= valE;
        end
    end

    assign valA = (32'(srcA) < NREGS) ? regs[srcA] : '0;
    assign valB = (32'(srcB) < NREGS) ? regs[srcB] : '0;
endmodule

// File: rtl/decode_stage.sv
// Y86-64 decode stage: D pipeline register, register ID decode, register file and operand forwarding.
module decode_stage
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREGS  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              D_stall,
    input  logic              D_bubble,
    input  logic [2:0]        f_stat,
    input  logic [3:0]        f_icode,
    input  logic [3:0]        f_ifun,
    input  logic [3:0]        f_rA,
    input  logic [3:0]        f_rB,
    input  logic [DATA_W-1:0] f_valC,
    input  logic [DATA_W-1:0] f_valP,
    input  logic [3:0]        e_dstE,
    input  logic [DATA_W-1:0] e_valE,
    input  logic [3:0]        M_dstM,
    input  logic [DATA_W-1:0] m_valM,
    input  logic [3:0]        M_dstE,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [3:0]        W_dstM,
    input  logic [DATA_W-1:0] W_valM,
    input  logic [3:0]        W_dstE,
    input  logic [DATA_W-1:0] W_valE,
    output logic [3:0]        D_icode,
    output logic [2:0]        d_stat,
    output logic [3:0]        d_icode,
    output logic [3:0]        d_ifun,
    output logic [DATA_W-1:0] d_valC,
    output logic [3:0]        d_srcA,
    output logic [3:0]        d_srcB,
    output logic [3:0]        d_dstE,
    output logic [3:0]        d_dstM,
    output logic [DATA_W-1:0] d_valA,
    output logic [DATA_W-1:0] d_valB
);
    typedef struct packed {
        logic [2:0]        stat;
        logic [3:0]        icode;
        logic [3:0]        ifun;
        logic [3:0]        rA;
        logic [3:0]        rB;
        logic [DATA_W-1:0] valC;
        logic [DATA_W-1:0] valP;
    } dReg_t;

    localparam dReg_t BUBBLE = '{stat: SAOK, icode: INOP, ifun: 4'h0, rA: RNONE, rB: RNONE,
                                 valC: '0, valP: '0};

    dReg_t dReg;
    logic [DATA_W-1:0] rfA, rfB;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        dReg <= BUBBLE;
        else if (D_bubble) dReg <= BUBBLE;
        else if (!D_stall) dReg <= '{stat: f_stat, icode: f_icode, ifun: f_ifun, rA: f_rA,
                                     rB: f_rB, valC: f_valC, valP: f_valP};
    end

    always_comb begin
        d_srcA = RNONE;
        d_srcB = RNONE;
        d_dstE = RNONE;
        d_dstM = RNONE;
        case (dReg.icode)
            IRRMOVQ: begin d_srcA = dReg.rA; d_dstE = dReg.rB; end
            IIRMOVQ: d_dstE = dReg.rB;
            IRMMOVQ: begin d_srcA = dReg.rA; d_srcB = dReg.rB; end
            IMRMOVQ: begin d_srcB = dReg.rB; d_dstM = dReg.rA; end
            IOPQ:    begin d_srcA = dReg.rA; d_srcB = dReg.rB; d_dstE = dReg.rB; end
            ICALL:   begin d_srcB = RSP; d_dstE = RSP; end
            IRET:    begin d_srcA = RSP; d_srcB = RSP; d_dstE = RSP; end
            IPUSHQ:  begin d_srcA = dReg.rA; d_srcB = RSP; d_dstE = RSP; end
            IPOPQ:   begin d_srcA = RSP; d_srcB = RSP; d_dstE = RSP; d_dstM = dReg.rA; end
            default: ;
        endcase
    end

    y86_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) uRegfile (
        .clk  (clk),
        .rst_n(rst_n),
        .srcA (d_srcA),
        .srcB (d_srcB),
        .valA (rfA),
        .valB (rfB),
        .dstE (W_dstE),
        .valE (W_valE),
        .dstM (W_dstM),
        .valM (W_valM)
    );

    // Youngest producer first; W-stage hits also cover same-cycle write-then-read.
    function automatic logic [DATA_W-1:0] fwd(
        input logic [3:0] src, input logic [DATA_W-1:0] rfv,
        input logic [3:0] eD, input logic [DATA_W-1:0] eV,
        input logic [3:0] mmD, input logic [DATA_W-1:0] mmV,
        input logic [3:0] meD, input logic [DATA_W-1:0] meV,
        input logic [3:0] wmD, input logic [DATA_W-1:0] wmV,
        input logic [3:0] weD, input logic [DATA_W-1:0] weV);
        if (src == RNONE) return '0;
        if (src == eD)    return eV;
        if (src == mmD)   return mmV;
        if (src == meD)   return meV;
        if (src == wmD)   return wmV;
        if (src == weD)   return weV;
        return rfv;
    endfunction

    always_comb begin
        d_valB = fwd(d_srcB, rfB, e_dstE, e_valE, M_dstM, m_valM, M_dstE, M_valE,
                     W_dstM, W_valM, W_dstE, W_valE);
        if (dReg.icode == ICALL || dReg.icode == IJXX)
            d_valA = dReg.valP;
        else
            d_valA = fwd(d_srcA, rfA, e_dstE, e_valE, M_dstM, m_valM, M_dstE, M_valE,
                         W_dstM, W_valM, W_dstE, W_valE);
    end

    assign D_icode = dReg.icode;
    assign d_stat  = dReg.stat;
    assign d_icode = dReg.icode;
    assign d_ifun  = dReg.ifun;
    assign d_valC  = dReg.valC;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: vector table for decode/forwarding plus reset, stall, bubble and write sequences.
module tb_decode_stage;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              D_stall = 1'b0, D_bubble = 1'b0;
    logic [2:0]        f_stat = 3'd1;
    logic [3:0]        f_icode = 4'h1, f_ifun = 4'h0, f_rA = 4'hF, f_rB = 4'hF;
    logic [DATA_W-1:0] f_valC = '0, f_valP = '0;
    logic [3:0]        e_dstE = 4'hF, M_dstM = 4'hF, M_dstE = 4'hF, W_dstM = 4'hF, W_dstE = 4'hF;
    logic [DATA_W-1:0] e_valE = '0, m_valM = '0, M_valE = '0, W_valM = '0, W_valE = '0;
    logic [3:0]        D_icode, d_icode, d_ifun, d_srcA, d_srcB, d_dstE, d_dstM;
    logic [2:0]        d_stat;
    logic [DATA_W-1:0] d_valC, d_valA, d_valB;

    int nCmp = 0, nErr = 0;

    decode_stage #(.DATA_W(DATA_W), .NREGS(15)) dut (
        .clk(clk), .rst_n(rst_n), .D_stall(D_stall), .D_bubble(D_bubble),
        .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
        .f_valC(f_valC), .f_valP(f_valP),
        .e_dstE(e_dstE), .e_valE(e_valE), .M_dstM(M_dstM), .m_valM(m_valM),
        .M_dstE(M_dstE), .M_valE(M_valE), .W_dstM(W_dstM), .W_valM(W_valM),
        .W_dstE(W_dstE), .W_valE(W_valE),
        .D_icode(D_icode), .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun),
        .d_valC(d_valC), .d_srcA(d_srcA), .d_srcB(d_srcB), .d_dstE(d_dstE),
        .d_dstM(d_dstM), .d_valA(d_valA), .d_valB(d_valB)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  stat;
        logic [3:0]  icode, ifun, rA, rB;
        logic [63:0] valC, valP;
        logic [3:0]  eD, mmD, meD, wmD, weD;
        logic [63:0] eV, mmV, meV, wmV, weV;
        logic [3:0]  xSrcA, xSrcB, xDstE, xDstM;
        logic [63:0] xValA, xValB;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [63:0] vp);
        f_stat = 3'd1; f_icode = ic; f_ifun = 4'h0; f_rA = ra; f_rB = rb;
        f_valC = '0; f_valP = vp;
    endtask

    task automatic clearFwd();
        e_dstE = 4'hF; M_dstM = 4'hF; M_dstE = 4'hF; W_dstM = 4'hF; W_dstE = 4'hF;
        e_valE = '0; m_valM = '0; M_valE = '0; W_valM = '0; W_valE = '0;
    endtask

    function automatic vec_t mk(
        input logic [2:0] st, input logic [3:0] ic, input logic [3:0] fn,
        input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp,
        input logic [3:0] eD, input logic [63:0] eV, input logic [3:0] mmD, input logic [63:0] mmV,
        input logic [3:0] meD, input logic [63:0] meV, input logic [3:0] wmD, input logic [63:0] wmV,
        input logic [3:0] weD, input logic [63:0] weV,
        input logic [3:0] sA, input logic [3:0] sB, input logic [3:0] dE, input logic [3:0] dM,
        input logic [63:0] vA, input logic [63:0] vB);
        vec_t v;
        v.stat = st; v.icode = ic; v.ifun = fn; v.rA = ra; v.rB = rb; v.valC = vc; v.valP = vp;
        v.eD = eD; v.eV = eV; v.mmD = mmD; v.mmV = mmV; v.meD = meD; v.meV = meV;
        v.wmD = wmD; v.wmV = wmV; v.weD = weD; v.weV = weV;
        v.xSrcA = sA; v.xSrcB = sB; v.xDstE = dE; v.xDstM = dM; v.xValA = vA; v.xValB = vB;
        return v;
    endfunction

    initial begin
        // Register file state when the table runs: r3 = 0x55, all others 0.
        //              stat ic  fn  rA  rB  valC   valP   e          mM         mE         wM         wE         srcA srcB dstE dstM valA  valB
        vecs.push_back(mk(1, 6, 0, 3, 3, 64'h0, 64'h0, 15, 0,     15, 0,     15, 0,     15, 0,     15, 0,     3,  3,  3,  15, 'h55, 'h55)); // opq reads r3
        vecs.push_back(mk(1, 2, 0, 2, 5, 64'h0, 64'h0, 2, 'h11,   2, 'h22,   2, 'h33,   15, 0,     2, 'h44,   2,  15, 5,  15, 'h11, 0));    // e wins
        vecs.push_back(mk(1, 2, 0, 2, 5, 64'h0, 64'h0, 15, 'h11,  2, 'h22,   2, 'h33,   15, 0,     2, 'h44,   2,  15, 5,  15, 'h22, 0));    // M_dstM next
        vecs.push_back(mk(1, 2, 0, 2, 5, 64'h0, 64'h0, 15, 'h11,  15, 'h22,  2, 'h33,   15, 0,     2, 'h44,   2,  15, 5,  15, 'h33, 0));    // M_dstE next
        vecs.push_back(mk(1, 2, 0, 2, 5, 64'h0, 64'h0, 15, 0,     15, 0,     15, 0,     2, 'h66,   2, 'h44,   2,  15, 5,  15, 'h66, 0));    // W_dstM over W_dstE
        vecs.push_back(mk(1, 2, 0, 2, 5, 64'h0, 64'h0, 15, 0,     15, 0,     15, 0,     15, 0,     2, 'h44,   2,  15, 5,  15, 'h44, 0));    // W_dstE
        vecs.push_back(mk(1, 7, 3, 15, 15, 64'h100, 64'h20, 15, 'h99, 15, 0, 15, 0,     15, 0,     15, 0,     15, 15, 15, 15, 'h20, 0));    // jXX uses valP
        vecs.push_back(mk(1, 3, 0, 15, 1, 64'h7, 64'h0, 15, 'h99,  15, 0,    15, 0,     15, 0,     15, 0,     15, 15, 1,  15, 0,    0));    // F source gives 0
        vecs.push_back(mk(1, 8, 0, 15, 15, 64'h80, 64'h40, 15, 0,  15, 0,    15, 0,     15, 0,     15, 0,     15, 4,  4,  15, 'h40, 0));    // call
        vecs.push_back(mk(1, 5, 0, 1, 3, 64'h8, 64'h0, 15, 0,      15, 0,    15, 0,     15, 0,     15, 0,     15, 3,  15, 1,  0,    'h55)); // mrmovq
        vecs.push_back(mk(1, 11, 0, 6, 15, 64'h0, 64'h0, 15, 0,    15, 0,    4, 'h77,   15, 0,     15, 0,     4,  4,  4,  6,  'h77, 'h77)); // popq fwd rsp
        vecs.push_back(mk(1, 9, 0, 15, 15, 64'h0, 64'h0, 15, 0,    15, 0,    15, 0,     15, 0,     15, 0,     4,  4,  4,  15, 0,    0));    // ret
        vecs.push_back(mk(1, 10, 0, 3, 15, 64'h0, 64'h0, 15, 0,    15, 0,    15, 0,     15, 0,     15, 0,     3,  4,  4,  15, 'h55, 0));    // pushq
        vecs.push_back(mk(1, 4, 0, 3, 1, 64'h10, 64'h0, 15, 0,     15, 0,    15, 0,     15, 0,     15, 0,     3,  1,  15, 15, 'h55, 0));    // rmmovq
        vecs.push_back(mk(2, 0, 0, 3, 3, 64'h0, 64'h0, 15, 0,      15, 0,    15, 0,     15, 0,     15, 0,     15, 15, 15, 15, 0,    0));    // halt
        vecs.push_back(mk(4, 12, 5, 3, 3, 64'h0, 64'h0, 3, 'h99,   15, 0,    15, 0,     15, 0,     15, 0,     15, 15, 15, 15, 0,    0));    // unknown icode

        // Asynchronous reset, checked without a clock edge.
        #3 rst_n = 1'b0;
        #1;
        chk("rst D_icode", 64'(D_icode), 64'h1);
        chk("rst d_stat", 64'(d_stat), 64'h1);
        chk("rst d_srcA", 64'(d_srcA), 64'hF);
        chk("rst d_srcB", 64'(d_srcB), 64'hF);
        chk("rst d_dstE", 64'(d_dstE), 64'hF);
        chk("rst d_dstM", 64'(d_dstM), 64'hF);
        chk("rst d_valA", d_valA, 64'h0);
        chk("rst d_valB", d_valB, 64'h0);

        // Release reset while stalled: bubble must persist.
        D_stall = 1'b1;
        fetch(4'h6, 4'h3, 4'h3, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("stall after reset D_icode", 64'(D_icode), 64'h1);
        D_stall = 1'b0;
        fetch(4'h1, 4'hF, 4'hF, 64'h0);

        // irmovq writeback of r3, then read it back through the file.
        W_dstE = 4'h3; W_valE = 64'h55;
        tick();
        clearFwd();
        fetch(4'h6, 4'h3, 4'h3, 64'h0);
        tick();
        chk("rf read valA", d_valA, 64'h55);
        chk("rf read valB", d_valB, 64'h55);
        chk("rf read dstE", 64'(d_dstE), 64'h3);

        foreach (vecs[i]) begin
            f_stat = vecs[i].stat; f_icode = vecs[i].icode; f_ifun = vecs[i].ifun;
            f_rA = vecs[i].rA; f_rB = vecs[i].rB; f_valC = vecs[i].valC; f_valP = vecs[i].valP;
            clearFwd();
            tick();
            e_dstE = vecs[i].eD;  e_valE = vecs[i].eV;
            M_dstM = vecs[i].mmD; m_valM = vecs[i].mmV;
            M_dstE = vecs[i].meD; M_valE = vecs[i].meV;
            W_dstM = vecs[i].wmD; W_valM = vecs[i].wmV;
            W_dstE = vecs[i].weD; W_valE = vecs[i].weV;
            #1;
            chk($sformatf("v%0d d_stat", i), 64'(d_stat), 64'(vecs[i].stat));
            chk($sformatf("v%0d d_icode", i), 64'(d_icode), 64'(vecs[i].icode));
            chk($sformatf("v%0d d_ifun", i), 64'(d_ifun), 64'(vecs[i].ifun));
            chk($sformatf("v%0d d_valC", i), d_valC, vecs[i].valC);
            chk($sformatf("v%0d d_srcA", i), 64'(d_srcA), 64'(vecs[i].xSrcA));
            chk($sformatf("v%0d d_srcB", i), 64'(d_srcB), 64'(vecs[i].xSrcB));
            chk($sformatf("v%0d d_dstE", i), 64'(d_dstE), 64'(vecs[i].xDstE));
            chk($sformatf("v%0d d_dstM", i), 64'(d_dstM), 64'(vecs[i].xDstM));
            chk($sformatf("v%0d d_valA", i), d_valA, vecs[i].xValA);
            chk($sformatf("v%0d d_valB", i), d_valB, vecs[i].xValB);
            // Drop forwarding IDs before the next edge so no stray register writes occur.
            #1 clearFwd();
        end

        // Stall holds the D register against changing fetch inputs.
        fetch(4'h2, 4'h3, 4'h5, 64'h0);
        tick();
        D_stall = 1'b1;
        fetch(4'hB, 4'h6, 4'h1, 64'h0);
        tick();
        tick();
        chk("stall d_icode", 64'(d_icode), 64'h2);
        chk("stall d_srcA", 64'(d_srcA), 64'h3);
        chk("stall d_dstE", 64'(d_dstE), 64'h5);
        chk("stall d_valA", d_valA, 64'h55);
        D_bubble = 1'b1;
        tick();
        chk("bubble over stall D_icode", 64'(D_icode), 64'h1);
        chk("bubble d_srcA", 64'(d_srcA), 64'hF);
        D_stall = 1'b0; D_bubble = 1'b0;

        // Dual write to the same register: M port wins; writes to F are dropped.
        fetch(4'h1, 4'hF, 4'hF, 64'h0);
        W_dstE = 4'h4; W_valE = 64'h8; W_dstM = 4'h4; W_valM = 64'h9;
        tick();
        W_dstE = 4'hF; W_valE = 64'hDEAD; W_dstM = 4'hF; W_valM = 64'hBEEF;
        tick();
        clearFwd();
        fetch(4'hA, 4'h3, 4'hF, 64'h0);
        tick();
        chk("conflict pushq valB", d_valB, 64'h9);
        chk("F write keeps r3", d_valA, 64'h55);
        fetch(4'h6, 4'h0, 4'hE, 64'h0);
        tick();
        chk("F write keeps r0", d_valA, 64'h0);
        chk("F write keeps r14", d_valB, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Y86-64 pipeline decode stage, directly downstream of fetch.
- Consumes fetch outputs (f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP) through its own D pipeline register.
- Contains the architectural register file and the operand forwarding network.
- Produces d_* operands and register IDs for the E pipeline register, and exposes D_icode plus d_srcA/d_srcB to the hazard control unit.

Parameters:
- DATA_W, 64, datapath width of valC, valP and register values.
- NREGS, 15, architectural registers (IDs 0-14; ID 15 = RNONE).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- D_stall  in  1  hold D register contents
- D_bubble  in  1  load NOP bubble into D register
- f_stat  in  3  fetch status
- f_icode  in  4  fetched instruction code
- f_ifun  in  4  fetched function code
- f_rA, f_rB  in  4 each  fetched register specifiers
- f_valC  in  DATA_W  fetched constant
- f_valP  in  DATA_W  fetched next PC
- e_dstE  in  4  execute destination; e_valE in DATA_W is its value
- M_dstM  in  4  memory-load destination; m_valM in DATA_W is its value
- M_dstE  in  4  memory-stage E destination; M_valE in DATA_W is its value
- W_dstM  in  4  writeback M destination; W_valM in DATA_W is its value
- W_dstE  in  4  writeback E destination; W_valE in DATA_W is its value
- D_icode  out  4  registered icode, for hazard control
- d_stat  out  3  registered stat, passed through
- d_icode, d_ifun  out  4 each  passed through
- d_valC  out  DATA_W  passed through
- d_srcA, d_srcB, d_dstE, d_dstM  out  4 each  decoded register IDs
- d_valA, d_valB  out  DATA_W  forwarded operands

Behaviour:
- Reset (rst_n low, asynchronous):
  - D register loads the bubble: stat=SAOK(1), icode=INOP(1), ifun=0, rA=rB=RNONE(F), valC=valP=0.
  - All 15 registers clear to 0.
  - Resulting outputs: d_srcA=d_srcB=d_dstE=d_dstM=F, d_valA=d_valB=0.
- D register update, at each posedge:
  - D_bubble=1: load the bubble. D_bubble wins if D_stall is also 1.
  - Else D_stall=1: hold all fields.
  - Else: capture the f_* inputs.
- Decode from D fields, combinational (outputs valid one cycle after capture):
  - d_srcA = rA for IRRMOVQ(2), IRMMOVQ(4), IOPQ(6), IPUSHQ(A); RSP(4) for IPOPQ(B), IRET(9); else F.
  - d_srcB = rB for IOPQ, IRMMOVQ, IMRMOVQ(5); RSP for IPUSHQ, IPOPQ, ICALL(8), IRET; else F.
  - d_dstE = rB for IRRMOVQ, IIRMOVQ(3), IOPQ; RSP for IPUSHQ, IPOPQ, ICALL, IRET; else F.
  - d_dstM = rA for IMRMOVQ, IPOPQ; else F.
  - Unknown icode: all IDs F.
- d_valA:
  - ICALL or IJXX(7): D_valP.
  - Otherwise: forwarded value for d_srcA.
- Forwarding for src (applies to both d_valA and d_valB), first match wins:
  1. e_dstE → e_valE
  2. M_dstM → m_valM
  3. M_dstE → M_valE
  4. W_dstM → W_valM
  5. W_dstE → W_valE
  6. otherwise register file read
  - A match requires src != F.
  - src = F yields 0.
- Register file:
  - Two synchronous write ports, active on posedge when rst_n is high.
  - W_dstE != F writes W_valE; W_dstM != F writes W_valM.
  - Both write the same register: W_valM wins (popq %rsp semantics).
  - Write ID F is ignored.
  - Reads are combinational. Same-cycle read-after-write is covered by W forwarding.
- Reset deasserted mid-stall: the D register still holds the bubble until the first non-stall edge.

Decomposition:
- Shared package y86_pkg:
  - icode constants IHALT..IPOPQ
  - RNONE = 4'hF, RSP = 4'h4
  - stat codes SAOK=1, SHLT=2, SADR=3, SINS=4
- One sub-module y86_regfile:
  - 15x DATA_W registers
  - two combinational read ports, two write ports with M-port priority
  - async active-low clear

Test Plan:
- Reset: hold rst_n=0 mid-cycle → D_icode=1, d_srcA=d_srcB=d_dstE=d_dstM=F, d_valA=d_valB=0, immediately without a clock edge.
- irmovq then read: apply W_dstE=3, W_valE=0x55 for one edge. Then f_icode=6 (opq), rA=3, rB=3, with no E/M/W matches → next cycle d_valA=d_valB=0x55, d_dstE=3.
- Forwarding priority:
  - e_dstE=M_dstM=M_dstE=W_dstE=2 with values 0x11/0x22/0x33/0x44, src rA=2 → d_valA=0x11.
  - Drop e_dstE to F → d_valA=0x22.
- jXX/call: f_icode=7, f_valP=0x20 → d_valA=0x20, d_srcA=F.
- Stall/bubble:
  - Load rrmovq, then assert D_stall for 2 cycles with a different f_* → outputs unchanged.
  - Assert D_stall and D_bubble together → D_icode=1.
- Write conflict: W_dstE=W_dstM=4, W_valE=0x8, W_valM=0x9 → a later pushq shows d_valB=0x9; a write to ID F changes no register.
